// File: rtl/decodificador_gray_sw.sv
// Synchronises and debounces a switch Gray code, then registers its binary value.
// Optional illegal-step detection on each accepted code: define GRAY_ERR_EN.
module decodificador_gray_sw #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_sw,
  output logic [WIDTH-1:0] bin,
  output logic             bin_valid,
  output logic             gray_err
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stable, stable_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bin_valid_nxt;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stable_nxt    = stable;
    cand_nxt      = cand;
    cnt_nxt       = cnt;
    bin_nxt       = bin;
    bin_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s2 != stable) begin
          cand_nxt  = s2;
          cnt_nxt   = CNT_ONE;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        // A return to the accepted code is a glitch; a different code restarts the wait.
        if (s2 == stable) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (s2 != cand) begin
          cand_nxt = s2;
          cnt_nxt  = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          stable_nxt    = cand;
          bin_nxt       = g2b(cand);
          bin_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      cand      <= '0;
      cnt       <= '0;
      bin       <= '0;
      bin_valid <= 1'b0;
    end else begin
      s1        <= gray_sw;
      s2        <= s1;
      stable    <= stable_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      bin       <= bin_nxt;
      bin_valid <= bin_valid_nxt;
    end
  end

`ifdef GRAY_ERR_EN
  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += v[i] ? 1 : 0;
    end
    return n;
  endfunction

  logic gray_err_nxt;
  assign gray_err_nxt = bin_valid_nxt && (popcount(cand ^ stable) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err <= 1'b0;
    end else begin
      gray_err <= gray_err_nxt;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_decodificador_gray_sw.sv
// Directed bench for decodificador_gray_sw with DEBOUNCE_CYCLES=4.
module tb_decodificador_gray_sw;

  localparam int W = 4;
  localparam int D = 4;
`ifdef GRAY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gray_sw;
  logic [W-1:0] bin;
  logic         bin_valid;
  logic         gray_err;

  int checks = 0;
  int passed = 0;
  int vcount;
  int vfirst;
  int ecount;
  logic err_at_valid;

  always #5 clk = ~clk;

  decodificador_gray_sw #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_sw   (gray_sw),
    .bin       (bin),
    .bin_valid (bin_valid),
    .gray_err  (gray_err)
  );

  // Advance n cycles sampling on the falling edge; cycle i=1 follows the first rising edge.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bin_valid) begin
        if (vcount == 0) vfirst = i;
        vcount++;
        err_at_valid = gray_err;
      end
      if (gray_err) ecount++;
    end
  endtask

  task automatic clear_counts();
    vcount = 0;
    vfirst = -1;
    ecount = 0;
    err_at_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gray_sw = 4'b0000;
    clear_counts();
    run(2);
    checks++;
    if (bin !== 4'b0000 || bin_valid !== 1'b0 || gray_err !== 1'b0)
      $display("FAIL reset_state: bin=%b valid=%b err=%b, need 0000/0/0", bin, bin_valid, gray_err);
    else passed++;
    rst = 1'b0;
    clear_counts();
    run(20);
    checks++;
    if (vcount !== 0 || bin !== 4'b0000)
      $display("FAIL idle_zero: pulses=%0d bin=%b, need 0 pulses bin=0000", vcount, bin);
    else passed++;
  endtask

  task automatic test_latency();
    gray_sw = 4'b0001;
    clear_counts();
    run(5);
    checks++;
    if (vcount !== 0 || bin !== 4'b0000)
      $display("FAIL latency_early: pulses=%0d bin=%b, need 0 pulses bin=0000", vcount, bin);
    else passed++;
    run(1);
    checks++;
    if (bin_valid !== 1'b1 || bin !== 4'b0001)
      $display("FAIL latency_edge5: valid=%b bin=%b, need 1/0001", bin_valid, bin);
    else passed++;
    run(8);
    checks++;
    if (vcount !== 1)
      $display("FAIL latency_single: pulses=%0d, need 1", vcount);
    else passed++;
  endtask

  task automatic test_bounce();
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      gray_sw = 4'b0011;
      run(2);
      gray_sw = 4'b0001;
      run(2);
    end
    checks++;
    if (vcount !== 0 || bin !== 4'b0001)
      $display("FAIL bounce_hold: pulses=%0d bin=%b, need 0 pulses bin=0001", vcount, bin);
    else passed++;
    gray_sw = 4'b0011;
    run(12);
    checks++;
    if (vcount !== 1 || bin !== 4'b0010)
      $display("FAIL bounce_accept: pulses=%0d bin=%b, need 1 pulse bin=0010", vcount, bin);
    else passed++;
  endtask

  task automatic test_glitch();
    clear_counts();
    gray_sw = 4'b0111;
    run(2);
    gray_sw = 4'b0011;
    run(12);
    checks++;
    if (vcount !== 0 || bin !== 4'b0010)
      $display("FAIL glitch_reject: pulses=%0d bin=%b, need 0 pulses bin=0010", vcount, bin);
    else passed++;
  endtask

  task automatic test_gray_err();
    clear_counts();
    gray_sw = 4'b1101;
    run(12);
    checks++;
    if (vcount !== 1 || bin !== 4'b1001)
      $display("FAIL multi_bit_accept: pulses=%0d bin=%b, need 1 pulse bin=1001", vcount, bin);
    else passed++;
    checks++;
    if (err_at_valid !== ERR_EN || ecount !== int'(ERR_EN))
      $display("FAIL multi_bit_err: err=%b pulses=%0d, need %b/%0d", err_at_valid, ecount, ERR_EN, int'(ERR_EN));
    else passed++;
    clear_counts();
    gray_sw = 4'b1100;
    run(12);
    checks++;
    if (vcount !== 1 || bin !== 4'b1000)
      $display("FAIL single_step_accept: pulses=%0d bin=%b, need 1 pulse bin=1000", vcount, bin);
    else passed++;
    checks++;
    if (ecount !== 0)
      $display("FAIL single_step_err: err pulses=%0d, need 0", ecount);
    else passed++;
  endtask

  task automatic test_reset_mid_count();
    clear_counts();
    gray_sw = 4'b0000;
    run(12);
    checks++;
    if (vcount !== 1 || bin !== 4'b0000)
      $display("FAIL back_to_zero: pulses=%0d bin=%b, need 1 pulse bin=0000", vcount, bin);
    else passed++;
    clear_counts();
    gray_sw = 4'b1000;
    run(4);
    rst = 1'b1;
    run(1);
    checks++;
    if (vcount !== 0 || bin !== 4'b0000 || bin_valid !== 1'b0)
      $display("FAIL abort_reset: pulses=%0d bin=%b valid=%b, need 0/0000/0", vcount, bin, bin_valid);
    else passed++;
    rst = 1'b0;
    clear_counts();
    run(12);
    checks++;
    if (vcount !== 1 || bin !== 4'b1111 || vfirst !== 6)
      $display("FAIL redebounce: pulses=%0d bin=%b first=%0d, need 1/1111/6", vcount, bin, vfirst);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_glitch();
    test_gray_err();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
